// File: rtl/inst_loader_if.sv
// -----------------------------------------------------------------------------
// inst_loader_if
// Bundles the host byte stream and the instruction-RAM write port of
// inst_loader.
//   rx_valid/rx_data     : one-cycle byte strobe from the UART receiver
//   wr_en/wr_addr/wr_data: one-cycle write strobe, byte address, 32-bit word
//   busy/done/error      : load status (done and error are sticky)
//   cpu_reset_n          : active-low core reset, released once the image is in
// Modports:
//   master : host/environment side (drives the byte stream, observes results)
//   slave  : loader side
// -----------------------------------------------------------------------------
interface inst_loader_if #(
    parameter int unsigned NADDR_BITS = 8
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  wr_en;
    logic [NADDR_BITS-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  cpu_reset_n;

    modport master (
        output rx_valid, rx_data,
        input  wr_en, wr_addr, wr_data, busy, done, error, cpu_reset_n
    );

    modport slave (
        input  rx_valid, rx_data,
        output wr_en, wr_addr, wr_data, busy, done, error, cpu_reset_n
    );
endinterface

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Boot-time instruction-memory writer. Consumes a byte stream
//   {N[7:0], N[15:8], word0 b0..b3, word1 b0..b3, ... [, checksum]}
// and writes word k as {b3,b2,b1,b0} to byte address 4*k. The core is kept in
// reset (cpu_reset_n = 0) until the whole image has been written.
//
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : inst_loader_if.slave (byte stream in, RAM write port and status out)
//
// Optional feature: define INST_LOADER_CHECKSUM_EN to require one trailer byte
// such that the 8-bit sum of every stream byte (length, data, trailer) is 0.
// -----------------------------------------------------------------------------
module inst_loader #(
    parameter int unsigned NADDR_BITS = 8
) (
    input logic       clock,
    input logic       reset_n,
    inst_loader_if.slave bus
);

    localparam int unsigned Depth = 1 << (NADDR_BITS - 2);
    localparam logic [16:0] DepthW = 17'(Depth);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StLen0, StLen1, StData, StCheck, StFinish, StDone, StError
    } state_e;
`else
    typedef enum logic [2:0] {
        StLen0, StLen1, StData, StFinish, StDone, StError
    } state_e;
`endif

    state_e                state_q;
    logic [7:0]            len_lo_q;
    logic [15:0]           count_q;
    logic [15:0]           word_q;
    logic [1:0]            byte_q;
    logic [23:0]           shift_q;
    logic                  wr_en_q;
    logic [NADDR_BITS-1:0] wr_addr_q;
    logic [31:0]           wr_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic                  cpu_reset_n_q;

    logic [15:0] len_n;
    logic        last_word;

    assign len_n     = {bus.rx_data, len_lo_q};
    assign last_word = (word_q == (count_q - 16'd1));

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_n;
    assign sum_n = sum_q + bus.rx_data;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StLen0;
            len_lo_q      <= 8'h00;
            count_q       <= 16'h0000;
            word_q        <= 16'h0000;
            byte_q        <= 2'd0;
            shift_q       <= 24'h000000;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 32'h0000_0000;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cpu_reset_n_q <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q         <= 8'h00;
`endif
        end else begin
            // Write strobe is a single-cycle pulse.
            wr_en_q <= 1'b0;
            case (state_q)
                StLen0: begin
                    if (bus.rx_valid) begin
                        len_lo_q <= bus.rx_data;
                        busy_q   <= 1'b1;
                        state_q  <= StLen1;
`ifdef INST_LOADER_CHECKSUM_EN
                        sum_q    <= sum_n;
`endif
                    end
                end
                StLen1: begin
                    if (bus.rx_valid) begin
                        count_q <= len_n;
                        word_q  <= 16'h0000;
                        byte_q  <= 2'd0;
`ifdef INST_LOADER_CHECKSUM_EN
                        sum_q   <= sum_n;
`endif
                        if (len_n == 16'h0000) begin
                            state_q <= StFinish;
                        end else if ({1'b0, len_n} > DepthW) begin
                            state_q <= StError;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (bus.rx_valid) begin
                        // Bytes arrive LSB first; shift in from the top.
                        shift_q <= {bus.rx_data, shift_q[23:8]};
                        byte_q  <= byte_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                        sum_q   <= sum_n;
`endif
                        if (byte_q == 2'd3) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= {word_q[NADDR_BITS-3:0], 2'b00};
                            wr_data_q <= {bus.rx_data, shift_q};
                            word_q    <= word_q + 16'd1;
                            if (last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                                state_q <= StCheck;
`else
                                state_q <= StFinish;
`endif
                            end
                        end
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                StCheck: begin
                    if (bus.rx_valid) begin
                        if (sum_n == 8'h00) begin
                            state_q <= StFinish;
                        end else begin
                            state_q <= StError;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
`endif
                StFinish: begin
                    state_q       <= StDone;
                    done_q        <= 1'b1;
                    cpu_reset_n_q <= 1'b1;
                    busy_q        <= 1'b0;
                end
                StDone: begin
                    state_q <= StDone;
                end
                StError: begin
                    state_q <= StError;
                end
                default: begin
                    state_q <= StError;
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.cpu_reset_n = cpu_reset_n_q;

endmodule
